// File: rtl/buyruk_anabellek_denetleyici_pkg.sv
// Shared definitions for the instruction-fetch memory path.
// The instruction-cache controller imports this package too.
package buyruk_anabellek_denetleyici_pkg;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    YANIT = 2'd2,
    TAMAM = 2'd3
  } durum_t;

  localparam int OBEK_KELIME   = 4;
  localparam int KELIME_BIT    = 32;
  localparam int OBEK_BIT      = OBEK_KELIME * KELIME_BIT;
  localparam int SATIR_OFS_BIT = 4;

endpackage

// File: rtl/buyruk_anabellek_denetleyici_zaman_asimi_sayaci.sv
// Per-word watchdog: clear/enable counter that flags when SINIR cycles have elapsed.
// A SINIR of 0 keeps doldu_o permanently low.
module zaman_asimi_sayaci #(
  parameter int SINIR = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic temizle_i,
  input  logic sayac_en_i,
  output logic doldu_o
);

  localparam logic [31:0] SINIR_W = 32'(SINIR);

  logic [31:0] sayac_q, sayac_d;

  // Saturate rather than wrap so a disabled or stuck counter never aliases back to zero.
  always_comb begin
    sayac_d = sayac_q;
    if (temizle_i) begin
      sayac_d = '0;
    end else if (sayac_en_i && (sayac_q != '1)) begin
      sayac_d = sayac_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sayac_q <= '0;
    end else begin
      sayac_q <= sayac_d;
    end
  end

  assign doldu_o = (SINIR_W != 32'd0) && (sayac_q >= (SINIR_W - 32'd1));

endmodule

// File: rtl/buyruk_anabellek_denetleyici.sv
// Serves 128-bit block requests from the instruction cache as four 32-bit
// memory-bus transactions (beat, then response), with a per-word timeout.
module buyruk_anabellek_denetleyici
  import buyruk_anabellek_denetleyici_pkg::*;
#(
  parameter int ZAMAN_ASIMI = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         istek_i,
  input  logic [31:0]  adres_i,
  input  logic         oku_i,
  input  logic         yaz_i,
  input  logic [127:0] yazilacak_obek_i,
  output logic         anabellek_musait_o,
  output logic         anabellek_hazir_o,
  output logic [127:0] okunan_obek_o,
  output logic         hata_o,
  output logic         bellek_gecerli_o,
  input  logic         bellek_hazir_i,
  output logic [31:0]  bellek_adres_o,
  output logic         bellek_yaz_o,
  output logic [31:0]  bellek_yaz_veri_o,
  input  logic         bellek_yanit_gecerli_i,
  input  logic [31:0]  bellek_yanit_veri_i,
  output logic [1:0]   durum_o
);

  // Handshake: a beat transfers on a rising edge where bellek_gecerli_o and
  // bellek_hazir_i are both high; beat outputs stay fixed until then. The
  // response for that beat is accepted no earlier than the following cycle.

  durum_t durum_q, durum_d;
  logic [31-SATIR_OFS_BIT:0] taban_q, taban_d;
  logic                      yaz_q, yaz_d;
  logic [OBEK_BIT-1:0]       blok_q, blok_d;
  logic [1:0]                k_q, k_d;
  logic [OBEK_BIT-1:0]       okunan_q, okunan_d;
  logic                      hata_q, hata_d;
  logic                      sayac_temizle, sayac_en, zaman_doldu;

  zaman_asimi_sayaci #(.SINIR(ZAMAN_ASIMI)) u_zaman_asimi (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .temizle_i  (sayac_temizle),
    .sayac_en_i (sayac_en),
    .doldu_o    (zaman_doldu)
  );

  always_comb begin
    durum_d  = durum_q;
    taban_d  = taban_q;
    yaz_d    = yaz_q;
    blok_d   = blok_q;
    k_d      = k_q;
    okunan_d = okunan_q;
    hata_d   = hata_q;
    case (durum_q)
      BOSTA: begin
        hata_d = 1'b0;
        if (istek_i && (yaz_i || oku_i)) begin
          taban_d = adres_i[31:SATIR_OFS_BIT];
          yaz_d   = yaz_i;
          blok_d  = yazilacak_obek_i;
          k_d     = 2'd0;
          durum_d = ISTEK;
        end
      end
      ISTEK: begin
        if (bellek_hazir_i) begin
          durum_d = YANIT;
        end else if (zaman_doldu) begin
          durum_d = TAMAM;
          hata_d  = 1'b1;
        end
      end
      YANIT: begin
        if (bellek_yanit_gecerli_i) begin
          if (!yaz_q) begin
            okunan_d[KELIME_BIT*k_q +: KELIME_BIT] = bellek_yanit_veri_i;
          end
          if (k_q == 2'd3) begin
            durum_d = TAMAM;
          end else begin
            k_d     = k_q + 2'd1;
            durum_d = ISTEK;
          end
        end else if (zaman_doldu) begin
          durum_d = TAMAM;
          hata_d  = 1'b1;
        end
      end
      TAMAM: begin
        durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase

    // An aborted read must not hand back stale words from an earlier block.
    if (hata_d && !hata_q && !yaz_q) begin
      for (int j = 0; j < OBEK_KELIME; j++) begin
        if (j >= int'(k_q)) begin
          okunan_d[j*KELIME_BIT +: KELIME_BIT] = '0;
        end
      end
    end
  end

  assign sayac_temizle = (durum_d == ISTEK) && (durum_q != ISTEK);
  assign sayac_en      = (durum_q == ISTEK) || (durum_q == YANIT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q  <= BOSTA;
      taban_q  <= '0;
      yaz_q    <= 1'b0;
      blok_q   <= '0;
      k_q      <= 2'd0;
      okunan_q <= '0;
      hata_q   <= 1'b0;
    end else begin
      durum_q  <= durum_d;
      taban_q  <= taban_d;
      yaz_q    <= yaz_d;
      blok_q   <= blok_d;
      k_q      <= k_d;
      okunan_q <= okunan_d;
      hata_q   <= hata_d;
    end
  end

  assign anabellek_musait_o = (durum_q == BOSTA);
  assign anabellek_hazir_o  = (durum_q == TAMAM);
  assign hata_o             = (durum_q == TAMAM) && hata_q;
  assign okunan_obek_o      = okunan_q;
  assign bellek_gecerli_o   = (durum_q == ISTEK);
  assign bellek_adres_o     = bellek_gecerli_o ? {taban_q, k_q, 2'b00} : 32'd0;
  assign bellek_yaz_o       = bellek_gecerli_o && yaz_q;
  assign bellek_yaz_veri_o  = bellek_gecerli_o ? blok_q[KELIME_BIT*k_q +: KELIME_BIT] : 32'd0;
  assign durum_o            = durum_q;

endmodule

// File: tb/tb_buyruk_anabellek_denetleyici.sv
// Self-checking bench for the block-to-word memory controller: directed cases
// plus randomized transactions against a block-level reference model.
module tb_buyruk_anabellek_denetleyici;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         istek_i = 1'b0;
  logic [31:0]  adres_i = '0;
  logic         oku_i = 1'b0;
  logic         yaz_i = 1'b0;
  logic [127:0] yazilacak_obek_i = '0;
  logic         anabellek_musait_o, anabellek_hazir_o, hata_o;
  logic [127:0] okunan_obek_o;
  logic         bellek_gecerli_o, bellek_yaz_o;
  logic         bellek_hazir_i = 1'b0;
  logic [31:0]  bellek_adres_o, bellek_yaz_veri_o;
  logic         bellek_yanit_gecerli_i = 1'b0;
  logic [31:0]  bellek_yanit_veri_i = '0;
  logic [1:0]   durum_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  buyruk_anabellek_denetleyici #(.ZAMAN_ASIMI(8)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .istek_i                (istek_i),
    .adres_i                (adres_i),
    .oku_i                  (oku_i),
    .yaz_i                  (yaz_i),
    .yazilacak_obek_i       (yazilacak_obek_i),
    .anabellek_musait_o     (anabellek_musait_o),
    .anabellek_hazir_o      (anabellek_hazir_o),
    .okunan_obek_o          (okunan_obek_o),
    .hata_o                 (hata_o),
    .bellek_gecerli_o       (bellek_gecerli_o),
    .bellek_hazir_i         (bellek_hazir_i),
    .bellek_adres_o         (bellek_adres_o),
    .bellek_yaz_o           (bellek_yaz_o),
    .bellek_yaz_veri_o      (bellek_yaz_veri_o),
    .bellek_yanit_gecerli_i (bellek_yanit_gecerli_i),
    .bellek_yanit_veri_i    (bellek_yanit_veri_i),
    .durum_o                (durum_o)
  );

  // Observations of one block transaction, cycle 1 = cycle after the request.
  logic [31:0]  ob_adr [4];
  logic         ob_yaz [4];
  logic [31:0]  ob_veri[4];
  int           ob_cyc [4];
  int           ob_nbeat, ob_unstable, ob_hz_cyc;
  logic         ob_hata;
  logic [127:0] ob_blok;
  logic [127:0] exp_blok = '0;

  // Memory-side driver. stall_beat/stall_n hold bellek_hazir_i low; drop_beat
  // never answers that beat; noisy adds random waits and junk responses that
  // the controller must ignore.
  task automatic run_txn(input logic [31:0] adr, input logic yz, input logic ok,
                         input logic [127:0] wblk, input logic [127:0] rdat,
                         input int stall_beat, input int stall_n,
                         input int drop_beat, input bit noisy);
    int beat, wait_cnt, resp_due, resp_beat;
    bit fresh;
    beat = 0; wait_cnt = 0; resp_due = -1; resp_beat = 0; fresh = 1'b1;
    ob_nbeat = 0; ob_unstable = 0; ob_hz_cyc = -1; ob_hata = 1'b0; ob_blok = '0;
    @(negedge clk_i);
    istek_i = 1'b1; adres_i = adr; yaz_i = yz; oku_i = ok; yazilacak_obek_i = wblk;
    @(negedge clk_i);
    istek_i = 1'b0; yaz_i = 1'b0; oku_i = 1'b0;
    adres_i = $urandom; yazilacak_obek_i = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 1; c <= 200; c++) begin
      bellek_hazir_i = 1'b0;
      bellek_yanit_gecerli_i = 1'b0;
      bellek_yanit_veri_i = $urandom;
      if (anabellek_hazir_o) begin
        ob_hz_cyc = c; ob_hata = hata_o; ob_blok = okunan_obek_o;
        break;
      end
      if (resp_due == c) begin
        bellek_yanit_gecerli_i = 1'b1;
        bellek_yanit_veri_i = rdat[32*resp_beat +: 32];
      end
      if (bellek_gecerli_o && beat < 4) begin
        if (fresh) begin
          ob_adr[beat] = bellek_adres_o; ob_yaz[beat] = bellek_yaz_o;
          ob_veri[beat] = bellek_yaz_veri_o; ob_cyc[beat] = c;
          fresh = 1'b0; ob_nbeat++;
        end else if (bellek_adres_o !== ob_adr[beat] || bellek_yaz_o !== ob_yaz[beat] ||
                     bellek_yaz_veri_o !== ob_veri[beat]) begin
          ob_unstable++;
        end
        if ((beat == stall_beat && wait_cnt < stall_n) ||
            (noisy && wait_cnt < 2 && $urandom_range(0, 1) == 1)) begin
          wait_cnt++;
        end else begin
          bellek_hazir_i = 1'b1;
          if (noisy) bellek_yanit_gecerli_i = 1'b1;
          if (beat != drop_beat) resp_due = c + 1 + (noisy ? int'($urandom_range(0, 1)) : 0);
          resp_beat = beat; beat++; fresh = 1'b1; wait_cnt = 0;
        end
      end
      @(negedge clk_i);
    end
    bellek_hazir_i = 1'b0;
    bellek_yanit_gecerli_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_i = 1'b0;
    #1;
    tests_run++;
    if (anabellek_musait_o !== 1'b1 || durum_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: musait=%b durum=%0d, required musait=1 durum=0", anabellek_musait_o, durum_o);
    end
    tests_run++;
    if ({anabellek_hazir_o, hata_o, bellek_gecerli_o, bellek_yaz_o} !== 4'b0 ||
        bellek_adres_o !== 32'd0 || bellek_yaz_veri_o !== 32'd0 || okunan_obek_o !== 128'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: hz=%b hata=%b gec=%b yaz=%b adr=%h veri=%h blok=%h, required all 0",
               anabellek_hazir_o, hata_o, bellek_gecerli_o, bellek_yaz_o, bellek_adres_o,
               bellek_yaz_veri_o, okunan_obek_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_zero_wait_read();
    logic [127:0] rdat;
    bit bad;
    rdat = {32'h44, 32'h33, 32'h22, 32'h11};
    run_txn(32'h0000_1234, 1'b0, 1'b1, '0, rdat, -1, 0, -1, 1'b0);
    exp_blok = rdat;
    bad = (ob_nbeat != 4);
    for (int k = 0; k < 4; k++)
      if (ob_adr[k] !== 32'h1230 + 32'(4*k) || ob_yaz[k] !== 1'b0 || ob_cyc[k] != 1 + 2*k) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL zw_beats: n=%0d adr0=%h adr3=%h cyc0=%0d cyc3=%0d, required 4 beats 1230..123C at 1,3,5,7",
               ob_nbeat, ob_adr[0], ob_adr[3], ob_cyc[0], ob_cyc[3]);
    end
    tests_run++;
    if (ob_hz_cyc != 9 || ob_hata !== 1'b0) begin
      tests_failed++;
      $display("FAIL zw_hazir: cycle=%0d hata=%b, required cycle 9 hata 0", ob_hz_cyc, ob_hata);
    end
    tests_run++;
    if (ob_blok !== exp_blok) begin
      tests_failed++;
      $display("FAIL zw_block: got %h, required %h", ob_blok, exp_blok);
    end
    @(negedge clk_i);
    tests_run++;
    if (anabellek_hazir_o !== 1'b0 || anabellek_musait_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL zw_musait: hz=%b musait=%b at cycle 10, required hz=0 musait=1",
               anabellek_hazir_o, anabellek_musait_o);
    end
  endtask

  task automatic test_back_pressure();
    logic [127:0] rdat;
    bit bad;
    rdat = {$urandom, $urandom, $urandom, $urandom};
    run_txn(32'hABCD_0048, 1'b0, 1'b1, '0, rdat, 2, 3, -1, 1'b0);
    exp_blok = rdat;
    bad = (ob_nbeat != 4) || (ob_cyc[3] != 10);
    for (int k = 0; k < 4; k++)
      if (ob_adr[k] !== 32'hABCD_0040 + 32'(4*k)) bad = 1'b1;
    tests_run++;
    if (bad || ob_unstable != 0) begin
      tests_failed++;
      $display("FAIL bp_beats: n=%0d unstable=%0d cyc3=%0d adr2=%h, required 4 stable beats, cyc3=10 adr2=abcd0048",
               ob_nbeat, ob_unstable, ob_cyc[3], ob_adr[2]);
    end
    tests_run++;
    if (ob_hz_cyc != 12 || ob_blok !== exp_blok) begin
      tests_failed++;
      $display("FAIL bp_hazir: cycle=%0d blok=%h, required cycle 12 blok=%h", ob_hz_cyc, ob_blok, exp_blok);
    end
  endtask

  task automatic test_write();
    logic [127:0] wblk;
    bit bad;
    wblk = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    run_txn(32'h0000_0080, 1'b1, 1'b1, wblk, {$urandom, $urandom, $urandom, $urandom}, -1, 0, -1, 1'b0);
    bad = (ob_nbeat != 4);
    for (int k = 0; k < 4; k++)
      if (ob_adr[k] !== 32'h80 + 32'(4*k) || ob_yaz[k] !== 1'b1 || ob_veri[k] !== wblk[32*k +: 32]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL wr_beats: n=%0d adr1=%h yaz1=%b veri1=%h, required 4 write beats 80..8C, veri1=bbbbbbbb",
               ob_nbeat, ob_adr[1], ob_yaz[1], ob_veri[1]);
    end
    tests_run++;
    if (ob_hz_cyc != 9 || ob_hata !== 1'b0 || ob_blok !== exp_blok) begin
      tests_failed++;
      $display("FAIL wr_done: cycle=%0d hata=%b blok=%h, required cycle 9 hata 0 blok unchanged %h",
               ob_hz_cyc, ob_hata, ob_blok, exp_blok);
    end
  endtask

  task automatic test_timeout();
    logic [127:0] rdat;
    rdat = {$urandom, $urandom, $urandom, $urandom} | {4{32'h1}};
    run_txn($urandom, 1'b0, 1'b1, '0, rdat, -1, 0, 1, 1'b0);
    exp_blok = {96'd0, rdat[31:0]};
    tests_run++;
    if (ob_hz_cyc < 0 || ob_hata !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_pulse: hazir_cycle=%0d hata=%b, required hazir with hata=1", ob_hz_cyc, ob_hata);
    end
    tests_run++;
    if (ob_blok !== exp_blok) begin
      tests_failed++;
      $display("FAIL to_block: got %h, required %h", ob_blok, exp_blok);
    end
    @(negedge clk_i);
    tests_run++;
    if (hata_o !== 1'b0 || anabellek_hazir_o !== 1'b0 || anabellek_musait_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_single: hata=%b hz=%b musait=%b, required 0 0 1", hata_o, anabellek_hazir_o, anabellek_musait_o);
    end
    rdat = {$urandom, $urandom, $urandom, $urandom};
    run_txn($urandom, 1'b0, 1'b1, '0, rdat, -1, 0, -1, 1'b0);
    exp_blok = rdat;
    tests_run++;
    if (ob_hz_cyc != 9 || ob_hata !== 1'b0 || ob_blok !== exp_blok) begin
      tests_failed++;
      $display("FAIL to_recover: cycle=%0d hata=%b blok=%h, required 9 0 %h", ob_hz_cyc, ob_hata, ob_blok, exp_blok);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    @(negedge clk_i);
    istek_i = 1'b1; adres_i = 32'h0000_4560; oku_i = 1'b1;
    @(negedge clk_i);
    istek_i = 1'b0; oku_i = 1'b0; bellek_hazir_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      bellek_yanit_gecerli_i = (c == 2 || c == 4);
      bellek_yanit_veri_i = $urandom;
      @(negedge clk_i);
    end
    bellek_yanit_gecerli_i = 1'b0;
    tests_run++;
    if (bellek_gecerli_o !== 1'b0 || anabellek_musait_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rm_waiting: gec=%b musait=%b, required 0 0 while waiting for word 2", bellek_gecerli_o, anabellek_musait_o);
    end
    #2 rst_i = 1'b0;
    #1;
    tests_run++;
    if (anabellek_musait_o !== 1'b1 || anabellek_hazir_o !== 1'b0 || hata_o !== 1'b0 ||
        bellek_gecerli_o !== 1'b0 || okunan_obek_o !== 128'd0) begin
      tests_failed++;
      $display("FAIL rm_async: musait=%b hz=%b hata=%b gec=%b blok=%h, required 1 0 0 0 0",
               anabellek_musait_o, anabellek_hazir_o, hata_o, bellek_gecerli_o, okunan_obek_o);
    end
    exp_blok = '0;
    @(negedge clk_i);
    rst_i = 1'b1;
    bellek_hazir_i = 1'b0;
    bellek_yanit_gecerli_i = 1'b1;
    bellek_yanit_veri_i = $urandom | 32'h1;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      bellek_yanit_gecerli_i = 1'b0;
      if (anabellek_hazir_o || hata_o || bellek_gecerli_o || !anabellek_musait_o ||
          okunan_obek_o !== exp_blok) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL rm_late_resp: hz=%b gec=%b musait=%b blok=%h, required idle with blok 0",
               anabellek_hazir_o, bellek_gecerli_o, anabellek_musait_o, okunan_obek_o);
    end
  endtask

  task automatic test_ignore();
    bit bad;
    @(negedge clk_i);
    istek_i = 1'b1; adres_i = $urandom; oku_i = 1'b0; yaz_i = 1'b0;
    @(negedge clk_i);
    istek_i = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bellek_gecerli_o || !anabellek_musait_o || anabellek_hazir_o) bad = 1'b1;
      @(negedge clk_i);
    end
    tests_run++;
    if (bad || okunan_obek_o !== exp_blok) begin
      tests_failed++;
      $display("FAIL ignore_noqual: gec=%b musait=%b blok=%h, required no beat, musait=1, blok %h",
               bellek_gecerli_o, anabellek_musait_o, okunan_obek_o, exp_blok);
    end
  endtask

  task automatic test_random();
    logic [31:0]  adr;
    logic [127:0] wblk, rdat;
    logic [1:0]   sel;
    bit bad;
    for (int t = 0; t < 25; t++) begin
      adr  = $urandom;
      sel  = 2'($urandom_range(1, 3));
      wblk = {$urandom, $urandom, $urandom, $urandom};
      rdat = {$urandom, $urandom, $urandom, $urandom};
      run_txn(adr, sel[1], sel[0], wblk, rdat, -1, 0, -1, 1'b1);
      if (!sel[1]) exp_blok = rdat;
      bad = (ob_nbeat != 4);
      for (int k = 0; k < 4; k++) begin
        if (ob_adr[k] !== (adr & 32'hFFFF_FFF0) + 32'(4*k) || ob_yaz[k] !== sel[1]) bad = 1'b1;
        if (sel[1] && ob_veri[k] !== wblk[32*k +: 32]) bad = 1'b1;
      end
      tests_run++;
      if (bad) begin
        tests_failed++;
        $display("FAIL rnd_beats[%0d]: n=%0d adr0=%h yaz0=%b veri0=%h, required base %h yaz %b",
                 t, ob_nbeat, ob_adr[0], ob_yaz[0], ob_veri[0], adr & 32'hFFFF_FFF0, sel[1]);
      end
      tests_run++;
      if (ob_hz_cyc < 9 || ob_hata !== 1'b0 || ob_blok !== exp_blok) begin
        tests_failed++;
        $display("FAIL rnd_done[%0d]: cycle=%0d hata=%b blok=%h, required cycle>=9 hata 0 blok %h",
                 t, ob_hz_cyc, ob_hata, ob_blok, exp_blok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_back_pressure();
    test_write();
    test_timeout();
    test_reset_mid();
    test_ignore();
    test_random();
    repeat (2) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/buyruk_anabellek_denetleyici.md
Name: buyruk_anabellek_denetleyici

Overview:
- Main-memory side of the fetch path. Sits directly upstream of the instruction-cache controller and serves its 128-bit block requests.
- Converts one block request into four sequential 32-bit word transactions on the memory bus.
- Assembles the returned words into a block, or splits a supplied block into writes.
- Reports completion back to the cache controller with a one-cycle ready pulse.

Parameters:
ZAMAN_ASIMI, 1024, max cycles allowed per word transaction (beat wait plus response wait); 0 disables the timeout

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
istek_i  input  1  single-cycle block request from the cache controller
adres_i  input  32  request address; bits [3:0] ignored
oku_i  input  1  read request qualifier
yaz_i  input  1  write request qualifier; takes precedence over oku_i
yazilacak_obek_i  input  128  block to write; sampled with istek_i
anabellek_musait_o  output  1  controller idle, can accept a request
anabellek_hazir_o  output  1  one-cycle pulse: block transaction finished
okunan_obek_o  output  128  assembled read block
hata_o  output  1  one-cycle pulse with anabellek_hazir_o on timeout
bellek_gecerli_o  output  1  word beat valid on memory bus
bellek_hazir_i  input  1  memory accepts beat when high with bellek_gecerli_o
bellek_adres_o  output  32  word address of current beat
bellek_yaz_o  output  1  current beat is a write
bellek_yaz_veri_o  output  32  write data of current beat
bellek_yanit_gecerli_i  input  1  read data / write acknowledge for the outstanding beat
bellek_yanit_veri_i  input  32  read data

Behaviour:
- Reset (async assert, sync release): state BOSTA; anabellek_musait_o=1; all other outputs 0; okunan_obek_o=0; word counter=0; timeout counter=0.
- States: BOSTA, ISTEK, YANIT, TAMAM.
- BOSTA:
  - anabellek_musait_o=1.
  - On istek_i with (yaz_i or oku_i): latch base={adres_i[31:4],4'b0}, latch the write flag (=yaz_i), latch yazilacak_obek_i, clear the word counter k, go to ISTEK.
  - istek_i with neither qualifier: ignored.
  - istek_i in any other state: ignored. The cache controller guarantees this does not occur.
- ISTEK:
  - bellek_gecerli_o=1; bellek_adres_o=base+4*k; bellek_yaz_o=write flag; bellek_yaz_veri_o=block[32k+31:32k].
  - All beat outputs are registered, and are held stable until bellek_hazir_i is sampled high.
  - On handshake, go to YANIT.
- YANIT:
  - bellek_gecerli_o=0.
  - On bellek_yanit_gecerli_i: on reads, store bellek_yanit_veri_i into okunan_obek_o[32k+31:32k].
  - If k==3, go to TAMAM; else k+1, go to ISTEK.
  - A response arriving in the same cycle as the beat handshake is not accepted. The earliest accepted response is the cycle after the handshake.
- TAMAM: anabellek_hazir_o=1 for exactly one cycle, then BOSTA. okunan_obek_o remains valid and stable until the next accepted read's first response.
- Responses seen outside YANIT: ignored.
- Word order: word k at address base+4k, placed at block bits [32k+31:32k]. This matches the cache controller's adres[3:2] selection.
- Latency, zero-wait memory (bellek_hazir_i=1, response the cycle after handshake), request accepted at cycle T:
  - beats at T+1, T+3, T+5, T+7;
  - responses at T+2, T+4, T+6, T+8;
  - anabellek_hazir_o at T+9;
  - anabellek_musait_o high again at T+10.
- Timeout:
  - Counter is cleared on every state entry into ISTEK and increments in ISTEK/YANIT.
  - When it reaches ZAMAN_ASIMI (nonzero), drop bellek_gecerli_o and go to TAMAM with hata_o=1.
  - The unfilled words of okunan_obek_o are forced to 0.
  - The cache controller must not hang.
- Address arithmetic: modulo 2^32. base+12 never crosses a 16-byte line.
- Reset mid-transaction: return to BOSTA immediately. No hazir/hata pulse. The outstanding memory response is discarded.

Decomposition:
- Shared package:
  - state encodings (BOSTA, ISTEK, YANIT, TAMAM);
  - OBEK_KELIME=4;
  - KELIME_BIT=32;
  - OBEK_BIT=128;
  - line-offset width 4.
  The cache controller reuses these.
- One sub-module: zaman_asimi_sayaci (clear/enable/limit counter, limit-reached output, disabled when limit 0).

Test Plan:
- Zero-wait read, adres_i=0x0000_1234, memory returns 0x11,0x22,0x33,0x44 -> beat addresses 0x1230, 0x1234, 0x1238, 0x123C; okunan_obek_o=0x00000044_00000033_00000022_00000011; anabellek_hazir_o at T+9; hata_o=0.
- Back-pressure: bellek_hazir_i low for 3 cycles on beat 2 -> address/data held stable; hazir delayed exactly 3 cycles (T+12).
- Write, yaz_i=1 (oku_i=1 too), block 0xDDDD..._CCCC..._BBBB..._AAAA..., adres 0x80 -> four beats with bellek_yaz_o=1, data AAAA/BBBB/CCCC/DDDD, at 0x80/0x84/0x88/0x8C; okunan_obek_o unchanged.
- Timeout: ZAMAN_ASIMI=8, no response to beat 1 -> hazir_o and hata_o pulse together; okunan_obek_o[127:32]=0, word 0 kept; next request served normally.
- rst_i asserted during YANIT of word 2 -> all outputs reset asynchronously; a late response after release is ignored; musait_o=1.
- istek_i with oku_i=yaz_i=0 -> no beat issued; musait_o stays 1.
